// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage feeding decode.
// Owns the PC, drives a req/ack instruction-ROM port and presents the
// registered IF/ID pair (id_addr, id_inst, id_valid). Honours stall and a
// MIPS-style single-delay-slot branch redirect from decode.
// Optional feature: define IF_ADDR_CHECK_EN to add fetch_adel. A misaligned
// PC then skips the ROM and injects a NOP flagged as an address error.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [31:0]       rom_rdata,
`ifdef IF_ADDR_CHECK_EN
  output logic              fetch_adel,
`endif
  output logic [ADDR_W-1:0] id_addr,
  output logic [31:0]       id_inst,
  output logic              id_valid
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_HOLD  = 2'b10;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_rom_req;
  logic [ADDR_W-1:0] r_id_addr;
  logic [31:0]       r_id_inst;
  logic              r_id_valid;
  logic              r_branch_pending;
  logic [ADDR_W-1:0] r_target;
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [31:0]       r_buf_inst;
`ifdef IF_ADDR_CHECK_EN
  logic              r_fetch_adel;
`endif

  logic              w_ack;
  logic              w_misaligned;
  logic              w_br_accept;
  logic              w_deliver_rom;
  logic              w_deliver_buf;
  logic              w_deliver_adel;
  logic              w_deliver;
  logic              w_park;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_rom_req_nxt;

  // Next-state, deliver/park decode and PC selection.
  always_comb begin
    w_ack          = rom_ack && r_rom_req;
`ifdef IF_ADDR_CHECK_EN
    w_misaligned   = (r_pc[1:0] != 2'b00);
`else
    w_misaligned   = 1'b0;
`endif
    w_br_accept    = branch_flag && r_id_valid && !stall;
    w_deliver_rom  = 1'b0;
    w_deliver_buf  = 1'b0;
    w_deliver_adel = 1'b0;
    w_park         = 1'b0;
    w_state_nxt    = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_misaligned) begin
          w_deliver_adel = !stall;
        end else if (w_ack) begin
          if (!stall) begin
            w_deliver_rom = 1'b1;
          end else begin
            w_park      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          // An empty buffer in HOLD cannot happen; fall back to fetching.
          w_deliver_buf = r_buf_valid;
          w_state_nxt   = S_FETCH;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_deliver = w_deliver_rom || w_deliver_buf || w_deliver_adel;

    // A branch accepted together with a deliver makes that word the delay slot.
    if (w_br_accept) begin
      w_next_pc = branch_addr;
    end else if (r_branch_pending) begin
      w_next_pc = r_target;
    end else begin
      w_next_pc = r_pc + PC_STEP;
    end

    if (w_deliver) begin
      w_pc_nxt = w_next_pc;
    end else begin
      w_pc_nxt = r_pc;
    end

`ifdef IF_ADDR_CHECK_EN
    w_rom_req_nxt = (w_state_nxt == S_FETCH) && (w_pc_nxt[1:0] == 2'b00);
`else
    w_rom_req_nxt = (w_state_nxt == S_FETCH);
`endif
  end

  // FSM state, PC and the registered ROM request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_rom_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_rom_req <= w_rom_req_nxt;
    end
  end

  // Skid buffer: parks a word that arrives while the pipe is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_inst  <= 32'h0000_0000;
    end else if (w_park) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_pc;
      r_buf_inst  <= rom_rdata;
    end else if (w_deliver_buf) begin
      r_buf_valid <= 1'b0;
    end else begin
      r_buf_valid <= r_buf_valid;
    end
  end

  // IF/ID register: hold on stall, load on deliver, otherwise insert a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_addr  <= '0;
      r_id_inst  <= 32'h0000_0000;
      r_id_valid <= 1'b0;
    end else if (stall) begin
      r_id_valid <= r_id_valid;
    end else if (w_deliver_rom) begin
      r_id_addr  <= r_pc;
      r_id_inst  <= rom_rdata;
      r_id_valid <= 1'b1;
    end else if (w_deliver_buf) begin
      r_id_addr  <= r_buf_addr;
      r_id_inst  <= r_buf_inst;
      r_id_valid <= 1'b1;
    end else if (w_deliver_adel) begin
      r_id_addr  <= r_pc;
      r_id_inst  <= 32'h0000_0000;
      r_id_valid <= 1'b1;
    end else begin
      r_id_inst  <= 32'h0000_0000;
      r_id_valid <= 1'b0;
    end
  end

  // Branch accepted before its delay slot arrives: remember the target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_pending <= 1'b0;
      r_target         <= '0;
    end else if (w_br_accept && !w_deliver) begin
      r_branch_pending <= 1'b1;
      r_target         <= branch_addr;
    end else if (w_deliver) begin
      r_branch_pending <= 1'b0;
    end else begin
      r_branch_pending <= r_branch_pending;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  // Address-error flag travels with the injected NOP until a real word lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_adel <= 1'b0;
    end else if (w_deliver_adel) begin
      r_fetch_adel <= 1'b1;
    end else if (w_deliver_rom || w_deliver_buf) begin
      r_fetch_adel <= 1'b0;
    end else begin
      r_fetch_adel <= r_fetch_adel;
    end
  end

  assign fetch_adel = r_fetch_adel;
`endif

  assign rom_req  = r_rom_req;
  assign rom_addr = r_pc;
  assign id_addr  = r_id_addr;
  assign id_inst  = r_id_inst;
  assign id_valid = r_id_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage. The ROM returns ~address as data.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_addr = 32'h0000_0000;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [31:0] rom_rdata;
  logic [31:0] id_addr;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IF_ADDR_CHECK_EN
  logic        fetch_adel;
`endif

  int n_vec = 0;
  int n_err = 0;

  assign rom_rdata = ~rom_addr;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch_flag(branch_flag),
    .branch_addr(branch_addr),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_rdata  (rom_rdata),
`ifdef IF_ADDR_CHECK_EN
    .fetch_adel (fetch_adel),
`endif
    .id_addr    (id_addr),
    .id_inst    (id_inst),
    .id_valid   (id_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and take the IDLE->FETCH edge; pc=BFC00000 afterwards.
  task automatic start();
    rst = 1'b0; stall = 1'b0; rom_ack = 1'b0; branch_flag = 1'b0; branch_addr = 32'h0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rom_ack = 1'b1;
    step();
    n_vec++; if (rom_req !== 1'b0) begin $display("FAIL rst_req got=%0b exp=0", rom_req); n_err++; end
    n_vec++; if (id_valid !== 1'b0) begin $display("FAIL rst_valid got=%0b exp=0", id_valid); n_err++; end
    n_vec++; if (id_addr !== 32'h0) begin $display("FAIL rst_addr got=%h exp=0", id_addr); n_err++; end
    n_vec++; if (id_inst !== 32'h0) begin $display("FAIL rst_inst got=%h exp=0", id_inst); n_err++; end
    n_vec++; if (rom_addr !== 32'hBFC0_0000) begin $display("FAIL rst_pc got=%h exp=bfc00000", rom_addr); n_err++; end
    rst = 1'b1;
    #1;
    n_vec++; if (rom_req !== 1'b0) begin $display("FAIL idle_req got=%0b exp=0", rom_req); n_err++; end
    step();
    n_vec++; if (rom_req !== 1'b1) begin $display("FAIL first_req got=%0b exp=1", rom_req); n_err++; end
    n_vec++; if (id_valid !== 1'b0) begin $display("FAIL first_valid got=%0b exp=0", id_valid); n_err++; end
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++; if (id_addr !== 32'hBFC0_0000 + 32'(4 * k)) begin $display("FAIL stream_addr[%0d] got=%h exp=%h", k, id_addr, 32'hBFC0_0000 + 32'(4 * k)); n_err++; end
      n_vec++; if (id_inst !== ~(32'hBFC0_0000 + 32'(4 * k))) begin $display("FAIL stream_inst[%0d] got=%h", k, id_inst); n_err++; end
      n_vec++; if (id_valid !== 1'b1) begin $display("FAIL stream_valid[%0d] got=%0b exp=1", k, id_valid); n_err++; end
    end
  endtask

  task automatic test_sparse_ack();
    logic [31:0] exp_pc;
    logic [31:0] exp_id;
    start();
    exp_pc = 32'hBFC0_0000;
    exp_id = 32'h0;
    for (int i = 0; i < 9; i++) begin
      rom_ack = (i % 3 == 2);
      step();
      if (i % 3 == 2) begin
        exp_id = exp_pc;
        exp_pc = exp_pc + 32'd4;
        n_vec++; if (id_valid !== 1'b1) begin $display("FAIL sparse_valid[%0d] got=%0b exp=1", i, id_valid); n_err++; end
        n_vec++; if (id_inst !== ~exp_id) begin $display("FAIL sparse_inst[%0d] got=%h exp=%h", i, id_inst, ~exp_id); n_err++; end
      end else begin
        n_vec++; if (id_valid !== 1'b0) begin $display("FAIL sparse_bubble[%0d] got=%0b exp=0", i, id_valid); n_err++; end
        n_vec++; if (id_inst !== 32'h0) begin $display("FAIL sparse_nop[%0d] got=%h exp=0", i, id_inst); n_err++; end
      end
      n_vec++; if (id_addr !== exp_id) begin $display("FAIL sparse_addr[%0d] got=%h exp=%h", i, id_addr, exp_id); n_err++; end
      n_vec++; if (rom_addr !== exp_pc) begin $display("FAIL sparse_pc[%0d] got=%h exp=%h", i, rom_addr, exp_pc); n_err++; end
    end
  endtask

  task automatic test_stall_hold();
    start();
    rom_ack = 1'b1;
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++; if (rom_req !== 1'b0) begin $display("FAIL hold_req[%0d] got=%0b exp=0", i, rom_req); n_err++; end
      n_vec++; if (id_addr !== 32'hBFC0_0000) begin $display("FAIL hold_addr[%0d] got=%h exp=bfc00000", i, id_addr); n_err++; end
      n_vec++; if (id_valid !== 1'b1) begin $display("FAIL hold_valid[%0d] got=%0b exp=1", i, id_valid); n_err++; end
    end
    stall = 1'b0;
    step();
    n_vec++; if (id_addr !== 32'hBFC0_0004) begin $display("FAIL unhold_addr got=%h exp=bfc00004", id_addr); n_err++; end
    n_vec++; if (id_inst !== ~32'hBFC0_0004) begin $display("FAIL unhold_inst got=%h", id_inst); n_err++; end
    n_vec++; if (rom_req !== 1'b1) begin $display("FAIL unhold_req got=%0b exp=1", rom_req); n_err++; end
    step();
    n_vec++; if (id_addr !== 32'hBFC0_0008) begin $display("FAIL after_hold_addr got=%h exp=bfc00008", id_addr); n_err++; end
  endtask

  // Stream until id_addr=BFC00010 with ack every cycle.
  task automatic run_to_bfc00010();
    start();
    rom_ack = 1'b1;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_branch_same_cycle();
    run_to_bfc00010();
    n_vec++; if (id_addr !== 32'hBFC0_0010) begin $display("FAIL br_pre got=%h exp=bfc00010", id_addr); n_err++; end
    branch_flag = 1'b1; branch_addr = 32'hBFC0_0100;
    step();
    branch_flag = 1'b0;
    n_vec++; if (id_addr !== 32'hBFC0_0014) begin $display("FAIL br_slot got=%h exp=bfc00014", id_addr); n_err++; end
    step();
    n_vec++; if (id_addr !== 32'hBFC0_0100) begin $display("FAIL br_target got=%h exp=bfc00100", id_addr); n_err++; end
    step();
    n_vec++; if (id_addr !== 32'hBFC0_0104) begin $display("FAIL br_after got=%h exp=bfc00104", id_addr); n_err++; end
  endtask

  task automatic test_branch_pending();
    run_to_bfc00010();
    rom_ack = 1'b0; branch_flag = 1'b1; branch_addr = 32'hBFC0_0100;
    step();
    n_vec++; if (id_valid !== 1'b0) begin $display("FAIL pend_bubble got=%0b exp=0", id_valid); n_err++; end
    branch_addr = 32'hBFC0_0200;
    step();
    branch_flag = 1'b0; rom_ack = 1'b1;
    n_vec++; if (rom_addr !== 32'hBFC0_0014) begin $display("FAIL pend_pc got=%h exp=bfc00014", rom_addr); n_err++; end
    step();
    n_vec++; if (id_addr !== 32'hBFC0_0014) begin $display("FAIL pend_slot got=%h exp=bfc00014", id_addr); n_err++; end
    n_vec++; if (rom_addr !== 32'hBFC0_0100) begin $display("FAIL pend_next_pc got=%h exp=bfc00100", rom_addr); n_err++; end
    step();
    n_vec++; if (id_addr !== 32'hBFC0_0100) begin $display("FAIL pend_target got=%h exp=bfc00100", id_addr); n_err++; end
  endtask

  task automatic test_pc_wrap();
    start();
    rom_ack = 1'b1;
    step();
    branch_flag = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_flag = 1'b0;
    step();
    n_vec++; if (id_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_top got=%h exp=fffffffc", id_addr); n_err++; end
    step();
    n_vec++; if (id_addr !== 32'h0000_0000) begin $display("FAIL wrap_zero got=%h exp=0", id_addr); n_err++; end
    n_vec++; if (id_valid !== 1'b1) begin $display("FAIL wrap_valid got=%0b exp=1", id_valid); n_err++; end
  endtask

  task automatic test_reset_midstream();
    start();
    rom_ack = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    #1;
    n_vec++; if (rom_req !== 1'b0) begin $display("FAIL mid_req got=%0b exp=0", rom_req); n_err++; end
    n_vec++; if (id_valid !== 1'b0) begin $display("FAIL mid_valid got=%0b exp=0", id_valid); n_err++; end
    step();
    rst = 1'b1;
    step();
    n_vec++; if (rom_addr !== 32'hBFC0_0000) begin $display("FAIL mid_pc got=%h exp=bfc00000", rom_addr); n_err++; end
    step();
    n_vec++; if (id_addr !== 32'hBFC0_0000) begin $display("FAIL mid_refetch got=%h exp=bfc00000", id_addr); n_err++; end
  endtask

  initial begin
    test_reset();
    test_sparse_ack();
    test_stall_hold();
    test_branch_same_cycle();
    test_branch_pending();
    test_pc_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
